psram_spi_bridge: RTL and testbench

// - Downstream of the external memory controller: turns its SRAM-style strobes (CE/WE/OE/BE/addr_strobe) into SPI PSRAM transactions.
// - Stalls the controller through memory_busy and returns read words on mem_rdata.
// - Lets the EP994A run with a serial PSRAM in place of parallel SRAM.

---
 rtl/psram_spi_bridge_if.sv | 27 ++
 rtl/psram_spi_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_psram_spi_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_spi_bridge_if.sv
// Memory-controller-side bus of the PSRAM bridge.
// The controller (master) drives the SRAM-style strobes, address and write data.
// The bridge (slave) returns mem_rdata and stalls the controller with memory_busy.
interface psram_spi_bridge_if;
    logic        select;       // address decode: access targets the PSRAM
    logic        addr_strobe;  // one-cycle pulse, mem_addr valid
    logic [22:0] mem_addr;     // word address
    logic [15:0] mem_wdata;    // big endian, [15:8] = even byte
    logic        mem_ce_n;
    logic        mem_we_n;
    logic        mem_oe_n;
    logic [1:0]  mem_be_n;     // [1] = high/even byte
    logic [15:0] mem_rdata;    // last completed read word
    logic        memory_busy;  // transaction in flight

    modport master (
        output select, addr_strobe, mem_addr, mem_wdata,
        output mem_ce_n, mem_we_n, mem_oe_n, mem_be_n,
        input  mem_rdata, memory_busy
    );

    modport slave (
        input  select, addr_strobe, mem_addr, mem_wdata,
        input  mem_ce_n, mem_we_n, mem_oe_n, mem_be_n,
        output mem_rdata, memory_busy
    );
endinterface

// File: rtl/psram_spi_bridge.sv
// psram_spi_bridge: converts SRAM-style CE/WE/OE/BE accesses into SPI PSRAM
// transactions (mode 0, MSB first) and stalls the controller with memory_busy.
//   clock, reset      system clock, async active-high reset
//   bus (slave)       controller strobes, address, write data, rdata, busy
//   spi_cs_n/sck/mosi PSRAM pins driven by the bridge
//   spi_miso          serial read data from the PSRAM
// Optional feature: define PSRAM_FAST_READ_EN to use the 0x0B fast-read
// command with 8 dummy SCK cycles; otherwise reads use 0x03.
module psram_spi_bridge #(
    parameter int CLK_DIV     = 1,  // clock cycles per SCK half-period (1..15)
    parameter int ARM_TIMEOUT = 7   // ARMED cycles before giving up
) (
    input  logic              clock,
    input  logic              reset,
    psram_spi_bridge_if.slave bus,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);
`ifdef PSRAM_FAST_READ_EN
    localparam logic [7:0] RD_CMD = 8'h0B;
    localparam bit         FAST   = 1'b1;
`else
    localparam logic [7:0] RD_CMD = 8'h03;
    localparam bit         FAST   = 1'b0;
`endif
    localparam logic [7:0] WR_CMD   = 8'h02;
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [7:0] TMO_LAST = 8'(ARM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ARMED, S_LEAD, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_TAIL, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [22:0] addr_q, addr_nxt;
    logic [15:0] wdata_q, wdata_nxt;
    logic [1:0]  be_q, be_nxt;
    logic        rw_q, rw_nxt;          // 1 = write
    logic [31:0] tx_q, tx_nxt;          // MOSI shifter, MSB on the pin
    logic [15:0] rx_q, rx_nxt;
    logic [5:0]  bit_q, bit_nxt;        // bits left in the phase, minus one
    logic [3:0]  div_q, div_nxt;        // cycles into the current SCK half
    logic [7:0]  tmo_q, tmo_nxt;
    logic        sck_q, sck_nxt;
    logic        cs_n_q, cs_n_nxt;
    logic        busy_q, busy_nxt;
    logic [15:0] rdata_q, rdata_nxt;

    logic        strobe, qual, half_end;
    logic [22:0] addr_sel;

    assign strobe   = bus.addr_strobe && bus.select;
    assign qual     = !bus.mem_ce_n && (!bus.mem_we_n || !bus.mem_oe_n);
    assign half_end = (div_q == DIV_LAST);
    // A strobe in the same cycle as qualification must win over the old address.
    assign addr_sel = strobe ? bus.mem_addr : addr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rw_q    <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            tmo_q   <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            be_q    <= be_nxt;
            rw_q    <= rw_nxt;
            tx_q    <= tx_nxt;
            rx_q    <= rx_nxt;
            bit_q   <= bit_nxt;
            div_q   <= div_nxt;
            tmo_q   <= tmo_nxt;
            sck_q   <= sck_nxt;
            cs_n_q  <= cs_n_nxt;
            busy_q  <= busy_nxt;
            rdata_q <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        be_nxt    = be_q;
        rw_nxt    = rw_q;
        tx_nxt    = tx_q;
        rx_nxt    = rx_q;
        bit_nxt   = bit_q;
        div_nxt   = div_q;
        tmo_nxt   = tmo_q;
        sck_nxt   = sck_q;
        cs_n_nxt  = cs_n_q;
        busy_nxt  = busy_q;
        rdata_nxt = rdata_q;
        unique case (state)
            S_IDLE: begin
                if (strobe) begin
                    addr_nxt  = bus.mem_addr;
                    busy_nxt  = 1'b1;
                    tmo_nxt   = '0;
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (strobe) addr_nxt = bus.mem_addr;
                if (qual) begin
                    wdata_nxt = bus.mem_wdata;
                    be_nxt    = bus.mem_be_n;
                    rw_nxt    = !bus.mem_we_n;
                    if (!bus.mem_we_n && bus.mem_be_n == 2'b11) begin
                        state_nxt = S_DONE;  // nothing enabled: no SPI traffic
                    end else begin
                        cs_n_nxt  = 1'b0;
                        div_nxt   = '0;
                        // Command and address go out back to back from one load;
                        // the address LSB selects the odd byte for a low-only write.
                        tx_nxt    = {(bus.mem_we_n ? RD_CMD : WR_CMD), addr_sel,
                                     (!bus.mem_we_n && bus.mem_be_n == 2'b10)};
                        state_nxt = S_LEAD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    tmo_nxt = tmo_q + 8'd1;
                end
            end
            S_LEAD: begin
                // CS-to-first-SCK setup: one SCK half-period with SCK low.
                if (half_end) begin
                    div_nxt   = '0;
                    bit_nxt   = 6'd7;
                    state_nxt = S_CMD;
                end else begin
                    div_nxt = div_q + 4'd1;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA: begin
                if (!half_end) begin
                    div_nxt = div_q + 4'd1;
                end else begin
                    div_nxt = '0;
                    sck_nxt = !sck_q;
                    if (!sck_q) begin
                        // Rising SCK: PSRAM output has been stable for a half period.
                        if (state == S_RDATA) rx_nxt = {rx_q[14:0], spi_miso};
                    end else begin
                        // Falling SCK: advance MOSI to the next bit.
                        tx_nxt  = {tx_q[30:0], 1'b0};
                        bit_nxt = bit_q - 6'd1;
                        if (bit_q == 6'd0) begin
                            case (state)
                                S_CMD: begin
                                    bit_nxt   = 6'd23;
                                    state_nxt = S_ADDR;
                                end
                                S_ADDR: begin
                                    if (rw_q) begin
                                        state_nxt = S_WDATA;
                                        if (be_q == 2'b00) begin
                                            bit_nxt = 6'd15;
                                            tx_nxt  = {wdata_q, 16'h0000};
                                        end else begin
                                            bit_nxt = 6'd7;
                                            tx_nxt  = {(be_q[0] ? wdata_q[15:8] : wdata_q[7:0]), 24'h000000};
                                        end
                                    end else if (FAST) begin
                                        bit_nxt   = 6'd7;
                                        state_nxt = S_DUMMY;
                                    end else begin
                                        bit_nxt   = 6'd15;
                                        state_nxt = S_RDATA;
                                    end
                                end
                                S_DUMMY: begin
                                    bit_nxt   = 6'd15;
                                    state_nxt = S_RDATA;
                                end
                                default: state_nxt = S_TAIL;
                            endcase
                        end
                    end
                end
            end
            S_TAIL: begin
                // Last-SCK-to-CS hold with SCK low.
                if (half_end) begin
                    div_nxt   = '0;
                    state_nxt = S_DONE;
                end else begin
                    div_nxt = div_q + 4'd1;
                end
            end
            S_DONE: begin
                cs_n_nxt = 1'b1;
                busy_nxt = 1'b0;
                // busy_q is high only on the first DONE cycle, so rdata updates once.
                if (busy_q && !rw_q) rdata_nxt = rx_q;
                if (bus.mem_ce_n) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign spi_cs_n        = cs_n_q;
    assign spi_sck         = sck_q;
    assign spi_mosi        = tx_q[31];
    assign bus.memory_busy = busy_q;
    assign bus.mem_rdata   = rdata_q;
endmodule

// File: tb/tb_psram_spi_bridge.sv
// Testbench for psram_spi_bridge: behavioural SPI PSRAM model plus a
// scoreboard of expected MOSI bytes, busy durations and read words.
module tb_psram_spi_bridge;
`ifdef PSRAM_FAST_READ_EN
    localparam logic [7:0] RCMD       = 8'h0B;
    localparam int         DUMMY_BITS = 8;
`else
    localparam logic [7:0] RCMD       = 8'h03;
    localparam int         DUMMY_BITS = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic spi_cs_n, spi_sck, spi_mosi;
    logic spi_miso = 1'b0;
    int   tests = 0;
    int   fails = 0;

    psram_spi_bridge_if bus();

    psram_spi_bridge dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clock = ~clock;

    // ---------------- PSRAM model ----------------
    logic [7:0]  mem [logic [23:0]];
    int          m_bits;
    logic [7:0]  m_cmd, m_byte;
    logic [23:0] m_addr;

    always @(negedge spi_cs_n) m_bits = 0;

    always @(posedge spi_sck) if (!spi_cs_n) begin
        if (m_bits < 8) m_cmd = {m_cmd[6:0], spi_mosi};
        else if (m_bits < 32) m_addr = {m_addr[22:0], spi_mosi};
        else if (m_cmd == 8'h02) begin
            m_byte = {m_byte[6:0], spi_mosi};
            if (m_bits % 8 == 7) mem[m_addr + 24'((m_bits - 32) / 8)] = m_byte;
        end
        m_bits++;
    end

    always @(negedge spi_sck) if (!spi_cs_n) begin
        int hdr;
        int k;
        logic [23:0] a;
        logic [7:0]  b;
        hdr = (m_cmd == 8'h0B) ? 40 : 32;
        if ((m_cmd == 8'h03 || m_cmd == 8'h0B) && m_bits >= hdr) begin
            k = m_bits - hdr;
            a = m_addr + 24'(k / 8);
            b = mem.exists(a) ? mem[a] : 8'h00;
            spi_miso = b[7 - k % 8];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_read;
        logic [15:0] rdata;
        int          cycles;
        string       name;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_mosi_q[$];
    int         exp_nb_q[$];
    logic [7:0] got[$];
    logic [7:0] cur;
    int         nbit;

    always @(negedge spi_cs_n) begin
        nbit = 0;
        got.delete();
    end

    always @(posedge spi_sck) if (!spi_cs_n) begin
        cur = {cur[6:0], spi_mosi};
        nbit++;
        if (nbit % 8 == 0) got.push_back(cur);
    end

    // Compare the leading bytes of each transaction when CS rises.
    always @(posedge spi_cs_n) begin
        if (reset) begin
            got.delete();
        end else if (exp_nb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spi_unexpected: saw %0d bytes, required no SPI traffic", got.size());
        end else begin
            int n;
            logic [7:0] e;
            n = exp_nb_q.pop_front();
            for (int i = 0; i < n; i++) begin
                e = exp_mosi_q.pop_front();
                tests++;
                if (i >= got.size()) begin
                    fails++;
                    $display("FAIL mosi_byte%0d: missing, required %h", i, e);
                end else if (got[i] !== e) begin
                    fails++;
                    $display("FAIL mosi_byte%0d: got %h, required %h", i, got[i], e);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic idle_bus();
        bus.select      = 1'b0;
        bus.addr_strobe = 1'b0;
        bus.mem_ce_n    = 1'b1;
        bus.mem_we_n    = 1'b1;
        bus.mem_oe_n    = 1'b1;
        bus.mem_be_n    = 2'b00;
    endtask

    task automatic push_exp(input bit rd, input logic [15:0] rdat, input int cyc, input string nm);
        exp_t e;
        e.is_read = rd;
        e.rdata   = rdat;
        e.cycles  = cyc;
        e.name    = nm;
        exp_q.push_back(e);
    endtask

    task automatic push_mosi(input logic [7:0] cmd, input logic [23:0] a, input int nd, input logic [15:0] d);
        exp_mosi_q.push_back(cmd);
        exp_mosi_q.push_back(a[23:16]);
        exp_mosi_q.push_back(a[15:8]);
        exp_mosi_q.push_back(a[7:0]);
        if (nd >= 1) exp_mosi_q.push_back(d[15:8]);
        if (nd >= 2) exp_mosi_q.push_back(d[7:0]);
        exp_nb_q.push_back(4 + nd);
    endtask

    // One access; pops the expected busy length / read word when busy falls.
    task automatic run_access(input logic [22:0] a, input bit we, input logic [1:0] be,
                              input logic [15:0] wd, input bit ce);
        exp_t e;
        int   cyc;
        @(negedge clock);
        bus.select      = 1'b1;
        bus.addr_strobe = 1'b1;
        bus.mem_addr    = a;
        bus.mem_wdata   = wd;
        bus.mem_be_n    = be;
        bus.mem_ce_n    = !ce;
        bus.mem_we_n    = !(ce && we);
        bus.mem_oe_n    = !(ce && !we);
        @(negedge clock);
        bus.addr_strobe = 1'b0;
        cyc = 0;
        while (bus.memory_busy === 1'b1 && cyc < 500) begin
            cyc++;
            @(negedge clock);
        end
        e = exp_q.pop_front();
        tests++;
        if (cyc !== e.cycles) begin
            fails++;
            $display("FAIL %s_busy_cycles: got %0d, required %0d", e.name, cyc, e.cycles);
        end
        if (e.is_read) begin
            tests++;
            if (bus.mem_rdata !== e.rdata) begin
                fails++;
                $display("FAIL %s_rdata: got %h, required %h", e.name, bus.mem_rdata, e.rdata);
            end
        end
        idle_bus();
        repeat (2) @(negedge clock);
    endtask

    task automatic check_mem(input logic [23:0] a, input logic [7:0] v, input string nm);
        logic [7:0] g;
        g = mem.exists(a) ? mem[a] : 8'hxx;
        tests++;
        if (g !== v) begin
            fails++;
            $display("FAIL %s: mem[%h] got %h, required %h", nm, a, g, v);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_bus();
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        repeat (3) @(negedge clock);
        tests += 5;
        if (spi_cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b, required 1", spi_cs_n); end
        if (spi_sck !== 1'b0) begin fails++; $display("FAIL reset_sck: got %b, required 0", spi_sck); end
        if (spi_mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b, required 0", spi_mosi); end
        if (bus.memory_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", bus.memory_busy); end
        if (bus.mem_rdata !== 16'h0000) begin fails++; $display("FAIL reset_rdata: got %h, required 0000", bus.mem_rdata); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_word_read();
        mem[24'h000020] = 8'hBE;
        mem[24'h000021] = 8'hEF;
        push_mosi(RCMD, 24'h000020, 0, 16'h0);
        push_exp(1'b1, 16'hBEEF, 2 + 2 * (48 + DUMMY_BITS) + 2, "word_read");
        run_access(23'h000010, 1'b0, 2'b00, 16'h0, 1'b1);
    endtask

    task automatic test_byte_write();
        mem[24'h000200] = 8'h77;
        mem[24'h000201] = 8'h33;
        push_mosi(8'h02, 24'h000201, 1, 16'hAB00);
        push_exp(1'b0, 16'h0, 2 + 2 * 40 + 2, "byte_write_lo");
        run_access(23'h000100, 1'b1, 2'b10, 16'h12AB, 1'b1);
        check_mem(24'h000201, 8'hAB, "byte_write_lo_target");
        check_mem(24'h000200, 8'h77, "byte_write_lo_neighbour");
        // High (even) byte only
        mem[24'h000300] = 8'h55;
        mem[24'h000301] = 8'h66;
        push_mosi(8'h02, 24'h000300, 1, 16'h9C00);
        push_exp(1'b0, 16'h0, 84, "byte_write_hi");
        run_access(23'h000180, 1'b1, 2'b01, 16'h9C11, 1'b1);
        check_mem(24'h000300, 8'h9C, "byte_write_hi_target");
        check_mem(24'h000301, 8'h66, "byte_write_hi_neighbour");
    endtask

    task automatic test_word_write();
        push_mosi(8'h02, 24'hFFFFFE, 2, 16'hCAFE);
        push_exp(1'b0, 16'h0, 100, "word_write");
        run_access(23'h7FFFFF, 1'b1, 2'b00, 16'hCAFE, 1'b1);
        check_mem(24'hFFFFFE, 8'hCA, "word_write_even");
        check_mem(24'hFFFFFF, 8'hFE, "word_write_odd");
        // No byte enabled: ARMED then DONE, no SPI traffic
        push_exp(1'b0, 16'h0, 2, "write_no_be");
        run_access(23'h000040, 1'b1, 2'b11, 16'h1234, 1'b1);
    endtask

    task automatic test_no_select();
        bit saw_busy, saw_cs;
        saw_busy = 1'b0;
        saw_cs   = 1'b0;
        @(negedge clock);
        bus.select      = 1'b0;
        bus.addr_strobe = 1'b1;
        bus.mem_addr    = 23'h000123;
        @(negedge clock);
        bus.addr_strobe = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.memory_busy !== 1'b0) saw_busy = 1'b1;
            if (spi_cs_n !== 1'b1) saw_cs = 1'b1;
            @(negedge clock);
        end
        tests += 2;
        if (saw_busy) begin fails++; $display("FAIL no_select_busy: got 1, required 0"); end
        if (saw_cs) begin fails++; $display("FAIL no_select_cs_n: got 0, required 1"); end
        idle_bus();
    endtask

    task automatic test_arm_timeout();
        push_exp(1'b0, 16'h0, 7, "arm_timeout");
        run_access(23'h000055, 1'b0, 2'b00, 16'h0, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clock);
        bus.select      = 1'b1;
        bus.addr_strobe = 1'b1;
        bus.mem_addr    = 23'h000020;
        bus.mem_ce_n    = 1'b0;
        bus.mem_oe_n    = 1'b0;
        @(negedge clock);
        bus.addr_strobe = 1'b0;
        repeat (19) @(negedge clock);
        reset = 1'b1;
        #1;
        tests += 3;
        if (spi_cs_n !== 1'b1) begin fails++; $display("FAIL midreset_cs_n: got %b, required 1", spi_cs_n); end
        if (bus.memory_busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b, required 0", bus.memory_busy); end
        if (bus.mem_rdata !== 16'h0000) begin fails++; $display("FAIL midreset_rdata: got %h, required 0000", bus.mem_rdata); end
        idle_bus();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        mem[24'h000040] = 8'h5A;
        mem[24'h000041] = 8'h5A;
        push_mosi(RCMD, 24'h000040, 0, 16'h0);
        push_exp(1'b1, 16'h5A5A, 100 + 2 * DUMMY_BITS, "read_after_reset");
        run_access(23'h000020, 1'b0, 2'b00, 16'h0, 1'b1);
        // Read back the word written at the top of memory
        push_mosi(RCMD, 24'hFFFFFE, 0, 16'h0);
        push_exp(1'b1, 16'hCAFE, 100 + 2 * DUMMY_BITS, "read_top");
        run_access(23'h7FFFFF, 1'b0, 2'b01, 16'h0, 1'b1);
        tests++;
        if (exp_nb_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d spi / %0d access entries left, required 0",
                     exp_nb_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write();
        test_word_write();
        test_no_select();
        test_arm_timeout();
        test_reset_mid_read();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
